// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_if
// Purpose  : Handshake and data bundle between the execute stage and the
//            sequential multiply/divide unit.
// Signals  : kill                 - abandon the operation in flight
//            in_valid / in_ready  - request handshake (operands op, a, b)
//            out_valid / out_ready- result handshake (result_lo, result_hi)
//            busy                 - unit not idle (stall hint)
// Modports : master (execute side), slave (muldiv_seq side)
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if #(
  parameter int RV = 16
);
  logic          kill;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [RV-1:0] result_lo;
  logic [RV-1:0] result_hi;
  logic          busy;

  modport master (
    output kill, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, busy
  );

  modport slave (
    input  kill, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result_lo, result_hi, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequential multiply/divide unit. Shift-add multiplier and
//            restoring divider retiring STEP bits per RUN cycle, MSB first.
//            Returns product hi:lo, or quotient (lo) and remainder (hi).
// Ports    : clk    - clock
//            reset  - synchronous, active-low reset
//            bus    - muldiv_seq_if.slave (kill, in_valid/in_ready, op, a, b,
//                     out_valid/out_ready, result_lo, result_hi, busy)
// Params   : RV   - operand/result width (multiple of STEP)
//            STEP - bits retired per RUN cycle (1, 2 or 4)
// Options  : MULDIV_SIGNED_EN - when defined, op[0] selects signed operation
//            and the FIX state applies the sign correction. When undefined,
//            every operation is unsigned and FIX is a plain pass-through.
// Latency  : accept edge E0, out_valid high after E0+RV/STEP+1;
//            divide by zero: out_valid high after E0+1.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
  parameter int RV   = 16,
  parameter int STEP = 1
) (
  input  wire         clk,
  input  wire         reset,
  muldiv_seq_if.slave bus
);

  localparam int             c_iters    = RV / STEP;
  localparam int             c_cw       = (c_iters > 1) ? $clog2(c_iters) : 1;
  localparam logic [c_cw-1:0] c_cnt_load = c_cw'(c_iters - 1);

  generate
    if ((STEP != 1 && STEP != 2 && STEP != 4) || (RV % STEP) != 0 || RV < 2)
    begin : g_param_check
      $error("muldiv_seq: STEP must be 1, 2 or 4 and divide RV");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_is_div;     // latched op[1]
  logic [RV-1:0]     r_a;          // multiplicand magnitude, consumed MSB first
  logic [RV-1:0]     r_b;          // multiplier / divisor magnitude
  // Multiply: full 2RV-bit product accumulator.
  // Divide  : {partial remainder, dividend bits shifting out / quotient in}.
  logic [2*RV-1:0]   r_acc;
  logic [c_cw-1:0]   r_cnt;
  logic [RV-1:0]     r_result_lo;
  logic [RV-1:0]     r_result_hi;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_div_zero;
  logic [RV-1:0]     w_a_mag;
  logic [RV-1:0]     w_b_mag;
  logic [RV-1:0]     w_fix_lo;
  logic [RV-1:0]     w_fix_hi;

  assign w_accept   = bus.in_valid & (r_state == S_IDLE) & ~bus.kill;
  assign w_div_zero = bus.op[1] & (bus.b == {RV{1'b0}});

  // --------------------------------------------------------------------------
  // Sign handling: operand magnitudes at accept, result correction in FIX
  // --------------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
  logic w_sa;
  logic w_sb;
  logic r_neg_lo;   // negate quotient, or the whole product
  logic r_neg_hi;   // negate remainder (follows the dividend sign)

  assign w_sa    = bus.op[0] & bus.a[RV-1];
  assign w_sb    = bus.op[0] & bus.b[RV-1];
  assign w_a_mag = w_sa ? ({RV{1'b0}} - bus.a) : bus.a;
  assign w_b_mag = w_sb ? ({RV{1'b0}} - bus.b) : bus.b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else if (w_accept) begin
      r_neg_lo <= w_sa ^ w_sb;
      r_neg_hi <= bus.op[1] ? w_sa : (w_sa ^ w_sb);
    end
  end

  // The product is negated as one 2RV-bit value; quotient and remainder are
  // negated independently. DIV(-2^(RV-1), -1) falls out naturally: the
  // magnitude quotient 2^(RV-1) is not negated and reads back as -2^(RV-1).
  always_comb begin
    w_fix_lo = r_acc[RV-1:0];
    w_fix_hi = r_acc[2*RV-1:RV];
    if (r_is_div) begin
      if (r_neg_lo) w_fix_lo = {RV{1'b0}} - r_acc[RV-1:0];
      if (r_neg_hi) w_fix_hi = {RV{1'b0}} - r_acc[2*RV-1:RV];
    end else if (r_neg_lo) begin
      {w_fix_hi, w_fix_lo} = {(2*RV){1'b0}} - r_acc;
    end
  end
`else
  assign w_a_mag  = bus.a;
  assign w_b_mag  = bus.b;
  assign w_fix_lo = r_acc[RV-1:0];
  assign w_fix_hi = r_acc[2*RV-1:RV];
`endif

  // --------------------------------------------------------------------------
  // RUN datapath
  // --------------------------------------------------------------------------
  logic [STEP-1:0]   w_digit;
  logic [2*RV-1:0]   w_mul_acc;
  logic [RV-1:0]     w_rem;
  logic [RV-1:0]     w_quo;
  logic [RV:0]       w_shift;
  logic [RV+1:0]     w_trial;
  logic [2*RV-1:0]   w_run_acc;

  assign w_digit   = r_a[RV-1 -: STEP];
  assign w_mul_acc = (r_acc << STEP)
                   + ({{RV{1'b0}}, r_b} * {{(2*RV-STEP){1'b0}}, w_digit});

  // STEP chained restoring sub-steps. The dividend MSB is shifted into the
  // partial remainder while the new quotient bit enters at the LSB, so the
  // low half turns from dividend into quotient over the iterations.
  always_comb begin
    w_rem   = r_acc[2*RV-1:RV];
    w_quo   = r_acc[RV-1:0];
    w_shift = '0;
    w_trial = '0;
    for (int i = 0; i < STEP; i++) begin
      w_shift = {w_rem, w_quo[RV-1]};
      w_trial = {1'b0, w_shift} - {2'b00, r_b};
      w_quo   = {w_quo[RV-2:0], ~w_trial[RV+1]};
      // Partial remainder stays below the divisor, so RV bits suffice.
      w_rem   = w_trial[RV+1] ? w_shift[RV-1:0] : w_trial[RV-1:0];
    end
  end

  assign w_run_acc = r_is_div ? {w_rem, w_quo} : w_mul_acc;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.kill) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == {c_cw{1'b0}}) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = bus.kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        // kill wins over a simultaneous result handshake
        if (bus.kill || (r_out_valid && bus.out_ready)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, accumulator and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_is_div    <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= bus.op[1];
            r_a      <= w_a_mag;
            r_b      <= w_b_mag;
            r_cnt    <= c_cnt_load;
            r_acc    <= bus.op[1] ? {{RV{1'b0}}, w_a_mag} : {(2*RV){1'b0}};
            if (w_div_zero) begin
              // Divide by zero bypasses RUN/FIX; the raw dividend is kept
              // as the remainder regardless of signedness.
              r_result_lo <= {RV{1'b1}};
              r_result_hi <= bus.a;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_run_acc;
          r_a   <= r_a << STEP;
          r_cnt <= r_cnt - c_cw'(1);
        end
        S_FIX: begin
          if (!bus.kill) begin
            r_result_lo <= w_fix_lo;
            r_result_hi <= w_fix_hi;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Entry through the divide-by-zero bypass arrives with out_valid
          // still low; it is raised one edge later.
          if (bus.kill || (r_out_valid && bus.out_ready)) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result_lo = r_result_lo;
  assign bus.result_hi = r_result_hi;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Scoreboard bench for muldiv_seq. Two instances: RV=16/STEP=1 and
//            RV=32/STEP=4. Directed vectors push expected results and
//            latencies into per-instance queues; monitors pop and compare on
//            each rising out_valid. Expected values follow MULDIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_seq_if #(.RV(16)) if16 ();
  muldiv_seq_if #(.RV(32)) if32 ();

  muldiv_seq #(.RV(16), .STEP(1)) u_dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  muldiv_seq #(.RV(32), .STEP(4)) u_dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // ---------------------------------------------------------------- monitors
  logic prev16 = 1'b0;
  logic prev32 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if16.out_valid && !prev16) begin
      if (q16.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL u16_unexpected_output: actual lo=0x%0h hi=0x%0h required=no output",
                 if16.result_lo, if16.result_hi);
      end else begin
        e = q16.pop_front();
        check("u16_result_lo", {16'h0, if16.result_lo}, e.lo);
        check("u16_result_hi", {16'h0, if16.result_hi}, e.hi);
        check("u16_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev16 = if16.out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if32.out_valid && !prev32) begin
      if (q32.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL u32_unexpected_output: actual lo=0x%0h hi=0x%0h required=no output",
                 if32.result_lo, if32.result_hi);
      end else begin
        e = q32.pop_front();
        check("u32_result_lo", if32.result_lo, e.lo);
        check("u32_result_hi", if32.result_hi, e.hi);
        check("u32_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev32 = if32.out_valid;
  end

  // ------------------------------------------------------------ 16-bit tasks
  task automatic issue16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] elo, input logic [15:0] ehi, input int elat,
                         input bit push);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!if16.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!if16.in_ready) timeout("u16_wait_in_ready");
    if16.op = op; if16.a = a; if16.b = b; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      e.lo = {16'h0, elo}; e.hi = {16'h0, ehi}; e.lat = elat; e.acc = cyc;
      q16.push_back(e);
    end
    if16.in_valid = 1'b0;
    if16.a = ~a; if16.b = ~b; if16.op = ~op;   // operands must be ignored after accept
  endtask

  // Waits (bounded) for out_valid; counts cycles where in_ready was high meanwhile.
  task automatic wait_valid16(output int ready_hi);
    int t;
    t = 0; ready_hi = 0;
    @(negedge clk);
    while (!if16.out_valid && t < 100) begin
      if (if16.in_ready) ready_hi++;
      @(negedge clk); t++;
    end
    if (!if16.out_valid) timeout("u16_wait_out_valid");
  endtask

  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] elo, input logic [15:0] ehi, input int elat);
    int rh;
    issue16(op, a, b, elo, ehi, elat, 1'b1);
    wait_valid16(rh);
    check("u16_in_ready_low_while_busy", 32'(rh), 32'd0);
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------ 32-bit tasks
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input int elat);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!if32.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!if32.in_ready) timeout("u32_wait_in_ready");
    if32.op = op; if32.a = a; if32.b = b; if32.in_valid = 1'b1;
    @(posedge clk); #1;
    e.lo = elo; e.hi = ehi; e.lat = elat; e.acc = cyc;
    q32.push_back(e);
    if32.in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!if32.out_valid && t < 100) begin @(negedge clk); t++; end
    if (!if32.out_valid) timeout("u32_wait_out_valid");
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int   rh;
    int   ov_seen;
    logic stable;
    exp_t e;

    if16.kill = 1'b0; if16.in_valid = 1'b0; if16.op = 2'b00;
    if16.a = '0; if16.b = '0; if16.out_ready = 1'b1;
    if32.kill = 1'b0; if32.in_valid = 1'b0; if32.op = 2'b00;
    if32.a = '0; if32.b = '0; if32.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", {31'h0, if16.out_valid}, 32'd0);
    check("reset_busy",      {31'h0, if16.busy},      32'd0);
    check("reset_in_ready",  {31'h0, if16.in_ready},  32'd1);
    check("reset_result_lo", {16'h0, if16.result_lo}, 32'd0);
    check("reset_result_hi", {16'h0, if16.result_hi}, 32'd0);
    reset = 1'b1;

    // Main function, RV=16 STEP=1
    run16(2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 17);
`ifdef MULDIV_SIGNED_EN
    run16(2'b01, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 17);
    run16(2'b11, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 17);
    run16(2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 17);
    run16(2'b01, 16'h0007, 16'hFFFE, 16'hFFF2, 16'hFFFF, 17);
`else
    run16(2'b01, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0004, 17);
    run16(2'b11, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 17);
    run16(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 17);
    run16(2'b01, 16'h0007, 16'hFFFE, 16'hFFF2, 16'h0006, 17);
`endif
    run16(2'b10, 16'd100,  16'd7,    16'd14,   16'd2,    17);
    run16(2'b10, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1);
    run16(2'b11, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1);

    // Back-pressure in DONE, then back-to-back request
    if16.out_ready = 1'b0;
    issue16(2'b00, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 17, 1'b1);
    wait_valid16(rh);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if16.result_lo !== 16'h2340 || if16.result_hi !== 16'h0001 ||
          if16.in_ready !== 1'b0 || if16.out_valid !== 1'b1) stable = 1'b0;
    end
    check("u16_backpressure_hold", {31'h0, stable}, 32'd1);
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    check("u16_idle_after_handshake", {31'h0, if16.in_ready},  32'd1);
    check("u16_out_valid_cleared",    {31'h0, if16.out_valid}, 32'd0);
    if16.op = 2'b10; if16.a = 16'd200; if16.b = 16'd9; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    e.lo = 32'd22; e.hi = 32'd2; e.lat = 17; e.acc = cyc;
    q16.push_back(e);
    if16.in_valid = 1'b0;
    check("u16_back_to_back_accept", {31'h0, if16.busy}, 32'd1);
    wait_valid16(rh);
    @(posedge clk); #1;

    // kill in DONE has priority over out_ready
    if16.out_ready = 1'b0;
    issue16(2'b00, 16'd2, 16'd3, 16'd6, 16'd0, 17, 1'b1);
    wait_valid16(rh);
    if16.kill = 1'b1; if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.kill = 1'b0;
    check("u16_kill_done_out_valid", {31'h0, if16.out_valid}, 32'd0);
    check("u16_kill_done_in_ready",  {31'h0, if16.in_ready},  32'd1);

    // kill five edges into RUN
    issue16(2'b00, 16'h00FF, 16'h00FF, 16'h0, 16'h0, 0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); if16.kill = 1'b1;
    @(posedge clk); #1;
    if16.kill = 1'b0;
    check("u16_kill_run_in_ready", {31'h0, if16.in_ready}, 32'd1);
    ov_seen = 0;
    repeat (25) begin @(negedge clk); if (if16.out_valid) ov_seen++; end
    check("u16_kill_run_no_output", 32'(ov_seen), 32'd0);
    run16(2'b00, 16'd3, 16'd4, 16'd12, 16'd0, 17);

    // kill together with in_valid in IDLE: not accepted
    @(negedge clk);
    if16.op = 2'b00; if16.a = 16'd5; if16.b = 16'd5; if16.in_valid = 1'b1; if16.kill = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0; if16.kill = 1'b0;
    check("u16_kill_idle_no_accept", {31'h0, if16.busy}, 32'd0);

    // reset mid-operation aborts with no output and clears results
    issue16(2'b00, 16'd5, 16'd5, 16'h0, 16'h0, 0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("u16_reset_mid_busy",      {31'h0, if16.busy},      32'd0);
    check("u16_reset_mid_result_lo", {16'h0, if16.result_lo}, 32'd0);
    ov_seen = 0;
    repeat (25) begin @(negedge clk); if (if16.out_valid) ov_seen++; end
    check("u16_reset_mid_no_output", 32'(ov_seen), 32'd0);

    // RV=32 STEP=4: latency 9 edges
    run32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 9);
`ifdef MULDIV_SIGNED_EN
    run32(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 9);
    run32(2'b11, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 9);
`else
    run32(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'h00000004, 9);
    run32(2'b11, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'h00000002, 9);
`endif
    run32(2'b10, 32'd1000000,  32'd7, 32'd142857,   32'd1,        9);
    run32(2'b10, 32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1);

    repeat (5) @(negedge clk);
    check("u16_scoreboard_drained", 32'(q16.size()), 32'd0);
    check("u32_scoreboard_drained", 32'(q32.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
